multicycle_ctrl_fsm: RTL and testbench

//  Main control state machine for the multi-cycle RV32I core. It sequences one shared ALU, a shared

---
 rtl/multicycle_ctrl_fsm_if.sv | 37 +++
 rtl/multicycle_ctrl_fsm.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_fsm_if.sv
// rtl/multicycle_ctrl_fsm_if.sv - control bundle between the multi-cycle FSM and the RV32I datapath
interface multicycle_ctrl_fsm_if #(
    parameter int RET_W = 32
);
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic             ir_write;
    logic             adr_src;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             alu_func7_en;
    logic [1:0]       result_src;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [RET_W-1:0] retired;

    modport master (
        input  opcode, funct3, zero, mem_ready,
        output pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
               alu_src_a, alu_src_b, alu_op, alu_func7_en, result_src,
               trap, trap_cause, retired
    );

    modport slave (
        output opcode, funct3, zero, mem_ready,
        input  pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
               alu_src_a, alu_src_b, alu_op, alu_func7_en, result_src,
               trap, trap_cause, retired
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multi-cycle RV32I main control FSM with memory timeout trap and retire counter
module multicycle_ctrl_fsm #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int RET_W          = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_ctrl_fsm_if.master  bus
);
    localparam int WC_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT_CYCLES - 1);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC_R, EXEC_I, ALUWB, BEQ, JAL, TRAP
    } state_t;

    state_t           state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [RET_W-1:0] retired_q;
    logic [1:0]       cause_q, cause_d;

    logic       in_mem, timeout, retire;
    logic       pc_write_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c;
    logic       adr_src_c, func7_en_c;
    logic [1:0] src_a_c, src_b_c, alu_op_c, result_src_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            wait_cnt_q <= '0;
            retired_q  <= '0;
            cause_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            cause_q    <= cause_d;
            if (retire) begin
                retired_q <= retired_q + RET_W'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        wait_cnt_d   = '0;
        pc_write_c   = 1'b0;
        ir_write_c   = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        adr_src_c    = 1'b0;
        func7_en_c   = 1'b0;
        src_a_c      = 2'b00;
        src_b_c      = 2'b00;
        alu_op_c     = 2'b00;
        result_src_c = 2'b00;

        in_mem  = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
        timeout = in_mem && !bus.mem_ready && (wait_cnt_q == WC_LAST);

        unique case (state_q)
            FETCH: begin
                mem_read_c   = 1'b1;
                src_b_c      = 2'b10;
                result_src_c = 2'b10;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                src_a_c = 2'b01;
                src_b_c = 2'b01;
                unique case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_R:              state_d = EXEC_R;
                    OP_I:              state_d = EXEC_I;
                    OP_BR:             state_d = BEQ;
                    OP_JAL:            state_d = JAL;
                    default: begin
                        state_d = TRAP;
                        cause_d = 2'b01;
                    end
                endcase
            end
            MEMADR: begin
                src_a_c = 2'b10;
                src_b_c = 2'b01;
                state_d = bus.opcode[5] ? MEMWR : MEMRD;
            end
            MEMRD: begin
                adr_src_c  = 1'b1;
                mem_read_c = 1'b1;
                if (bus.mem_ready) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                state_d      = FETCH;
            end
            MEMWR: begin
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
                if (bus.mem_ready) begin
                    state_d = FETCH;
                end
            end
            EXEC_R: begin
                src_a_c    = 2'b10;
                alu_op_c   = 2'b10;
                func7_en_c = 1'b1;
                state_d    = ALUWB;
            end
            EXEC_I: begin
                src_a_c    = 2'b10;
                src_b_c    = 2'b01;
                alu_op_c   = 2'b10;
                // instr[30] is only a real funct7 bit for srli/srai; elsewhere it is immediate
                func7_en_c = (bus.funct3 == 3'b101);
                state_d    = ALUWB;
            end
            ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = FETCH;
            end
            BEQ: begin
                src_a_c    = 2'b10;
                alu_op_c   = 2'b01;
                pc_write_c = bus.zero;
                state_d    = FETCH;
            end
            JAL: begin
                src_a_c    = 2'b01;
                src_b_c    = 2'b10;
                pc_write_c = 1'b1;
                state_d    = ALUWB;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // A ready in the final allowed cycle completes normally, so timeout requires mem_ready=0
        if (timeout) begin
            state_d = TRAP;
            cause_d = 2'b10;
        end
        if (in_mem && !bus.mem_ready && !timeout) begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
        end

        retire = (state_d == FETCH) &&
                 ((state_q == MEMWB) || (state_q == MEMWR) ||
                  (state_q == ALUWB) || (state_q == BEQ));
    end

    assign bus.pc_write     = pc_write_c  & ~reset;
    assign bus.ir_write     = ir_write_c  & ~reset;
    assign bus.mem_read     = mem_read_c  & ~reset;
    assign bus.mem_write    = mem_write_c & ~reset;
    assign bus.reg_write    = reg_write_c & ~reset;
    assign bus.adr_src      = adr_src_c;
    assign bus.alu_src_a    = src_a_c;
    assign bus.alu_src_b    = src_b_c;
    assign bus.alu_op       = alu_op_c;
    assign bus.alu_func7_en = func7_en_c;
    assign bus.result_src   = result_src_c;
    assign bus.trap         = (state_q == TRAP);
    assign bus.trap_cause   = cause_q;
    assign bus.retired      = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - scoreboard bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    localparam int S_FETCH  = 0;
    localparam int S_DECODE = 1;
    localparam int S_MEMADR = 2;
    localparam int S_MEMRD  = 3;
    localparam int S_MEMWB  = 4;
    localparam int S_MEMWR  = 5;
    localparam int S_EXEC_R = 6;
    localparam int S_EXEC_I = 7;
    localparam int S_ALUWB  = 8;
    localparam int S_BEQ    = 9;
    localparam int S_JAL    = 10;
    localparam int S_TRAP   = 11;

    typedef struct packed {
        logic        pc_write;
        logic        ir_write;
        logic        adr_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [1:0]  op;
        logic        f7;
        logic [1:0]  rs;
        logic        trap;
        logic [1:0]  cause;
        logic [31:0] ret;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if #(.RET_W(32)) bus ();

    multicycle_ctrl_fsm #(.TIMEOUT_CYCLES(16), .RET_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        exp_q[$];
    string       nm_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] ret_exp = 0;
    logic [1:0]  cause_exp = 2'b00;

    function automatic exp_t ex(input int s, input logic mr, input logic z, input logic f7e);
        exp_t e = '0;
        case (s)
            S_FETCH:  begin e.mem_read = 1; e.b = 2'b10; e.rs = 2'b10; e.ir_write = mr; e.pc_write = mr; end
            S_DECODE: begin e.a = 2'b01; e.b = 2'b01; end
            S_MEMADR: begin e.a = 2'b10; e.b = 2'b01; end
            S_MEMRD:  begin e.adr_src = 1; e.mem_read = 1; end
            S_MEMWB:  begin e.rs = 2'b01; e.reg_write = 1; end
            S_MEMWR:  begin e.adr_src = 1; e.mem_write = 1; end
            S_EXEC_R: begin e.a = 2'b10; e.op = 2'b10; e.f7 = 1; end
            S_EXEC_I: begin e.a = 2'b10; e.b = 2'b01; e.op = 2'b10; e.f7 = f7e; end
            S_ALUWB:  begin e.reg_write = 1; end
            S_BEQ:    begin e.a = 2'b10; e.op = 2'b01; e.pc_write = z; end
            S_JAL:    begin e.a = 2'b01; e.b = 2'b10; e.pc_write = 1; end
            S_TRAP:   begin e.trap = 1; end
            default:  e = '0;
        endcase
        return e;
    endfunction

    task automatic cyc(input logic rst, input logic [6:0] op, input logic [2:0] f3, input logic z,
                       input logic mr, input int s, input logic f7e, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rst;
        bus.opcode    = op;
        bus.funct3    = f3;
        bus.zero      = z;
        bus.mem_ready = mr;
        e = ex(s, mr, z, f7e);
        if (rst) begin
            e.pc_write = 0; e.ir_write = 0; e.mem_read = 0; e.mem_write = 0; e.reg_write = 0;
        end
        e.cause = cause_exp;
        e.ret   = ret_exp;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        if (rst) begin
            ret_exp   = 0;
            cause_exp = 2'b00;
        end
    endtask

    task automatic run_alu(input logic [6:0] op, input logic [2:0] f3, input int sx,
                           input logic f7e, input string nm);
        cyc(0, op, f3, 0, 1, S_FETCH,  0,   nm);
        cyc(0, op, f3, 0, 1, S_DECODE, 0,   nm);
        cyc(0, op, f3, 0, 1, sx,       f7e, nm);
        cyc(0, op, f3, 0, 1, S_ALUWB,  0,   nm);
        ret_exp++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  got;
            string nm;
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            got.pc_write  = bus.pc_write;
            got.ir_write  = bus.ir_write;
            got.adr_src   = bus.adr_src;
            got.mem_read  = bus.mem_read;
            got.mem_write = bus.mem_write;
            got.reg_write = bus.reg_write;
            got.a         = bus.alu_src_a;
            got.b         = bus.alu_src_b;
            got.op        = bus.alu_op;
            got.f7        = bus.alu_func7_en;
            got.rs        = bus.result_src;
            got.trap      = bus.trap;
            got.cause     = bus.trap_cause;
            got.ret       = bus.retired;
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL %s @%0t: got %h required %h", nm, $time, got, e);
            end
        end
    end

    initial begin
        reset         = 1'b1;
        bus.opcode    = 7'd0;
        bus.funct3    = 3'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;

        cyc(1, 7'd0, 3'd0, 0, 0, S_FETCH, 0, "reset");

        run_alu(OP_R, 3'b000, S_EXEC_R, 1, "add");

        cyc(0, OP_LD, 3'b010, 0, 1, S_FETCH,  0, "lw");
        cyc(0, OP_LD, 3'b010, 0, 1, S_DECODE, 0, "lw");
        cyc(0, OP_LD, 3'b010, 0, 1, S_MEMADR, 0, "lw");
        for (int i = 0; i < 3; i++) cyc(0, OP_LD, 3'b010, 0, 0, S_MEMRD, 0, "lw_wait");
        cyc(0, OP_LD, 3'b010, 0, 1, S_MEMRD,  0, "lw");
        cyc(0, OP_LD, 3'b010, 0, 1, S_MEMWB,  0, "lw");
        ret_exp++;

        cyc(0, OP_BR, 3'b000, 0, 1, S_FETCH,  0, "beq_taken");
        cyc(0, OP_BR, 3'b000, 0, 1, S_DECODE, 0, "beq_taken");
        cyc(0, OP_BR, 3'b000, 1, 1, S_BEQ,    0, "beq_taken");
        ret_exp++;
        cyc(0, OP_BR, 3'b000, 0, 1, S_FETCH,  0, "beq_not");
        cyc(0, OP_BR, 3'b000, 0, 1, S_DECODE, 0, "beq_not");
        cyc(0, OP_BR, 3'b000, 0, 1, S_BEQ,    0, "beq_not");
        ret_exp++;

        cyc(0, OP_ST, 3'b010, 0, 1, S_FETCH,  0, "sw");
        cyc(0, OP_ST, 3'b010, 0, 1, S_DECODE, 0, "sw");
        cyc(0, OP_ST, 3'b010, 0, 1, S_MEMADR, 0, "sw");
        cyc(0, OP_ST, 3'b010, 0, 0, S_MEMWR,  0, "sw_wait");
        cyc(0, OP_ST, 3'b010, 0, 1, S_MEMWR,  0, "sw");
        ret_exp++;

        cyc(0, OP_JAL, 3'b000, 0, 1, S_FETCH,  0, "jal");
        cyc(0, OP_JAL, 3'b000, 0, 1, S_DECODE, 0, "jal");
        cyc(0, OP_JAL, 3'b000, 0, 1, S_JAL,    0, "jal");
        cyc(0, OP_JAL, 3'b000, 0, 1, S_ALUWB,  0, "jal");
        ret_exp++;

        run_alu(OP_I, 3'b000, S_EXEC_I, 0, "addi");
        run_alu(OP_I, 3'b101, S_EXEC_I, 1, "srai");

        cyc(0, OP_BAD, 3'b000, 0, 1, S_FETCH,  0, "illegal");
        cyc(0, OP_BAD, 3'b000, 0, 1, S_DECODE, 0, "illegal");
        cause_exp = 2'b01;
        cyc(0, OP_BAD, 3'b000, 0, 1, S_TRAP,   0, "illegal_trap");
        cyc(0, OP_BAD, 3'b000, 1, 1, S_TRAP,   0, "illegal_trap");
        cyc(1, OP_BAD, 3'b000, 0, 1, S_TRAP,   0, "trap_reset");

        for (int i = 0; i < 16; i++) cyc(0, OP_R, 3'b000, 0, 0, S_FETCH, 0, "fetch_wait");
        cause_exp = 2'b10;
        cyc(0, OP_R, 3'b000, 0, 0, S_TRAP, 0, "timeout_trap");
        cyc(1, OP_R, 3'b000, 0, 0, S_TRAP, 0, "timeout_reset");

        for (int i = 0; i < 15; i++) cyc(0, OP_R, 3'b000, 0, 0, S_FETCH, 0, "fetch_wait2");
        cyc(0, OP_R, 3'b000, 0, 1, S_FETCH,  0, "last_cycle_ready");
        cyc(0, OP_R, 3'b000, 0, 1, S_DECODE, 0, "last_cycle_ready");
        cyc(0, OP_R, 3'b000, 0, 1, S_EXEC_R, 1, "last_cycle_ready");
        cyc(0, OP_R, 3'b000, 0, 1, S_ALUWB,  0, "last_cycle_ready");
        ret_exp++;

        cyc(0, OP_ST, 3'b010, 0, 1, S_FETCH,  0, "sw_abort");
        cyc(0, OP_ST, 3'b010, 0, 1, S_DECODE, 0, "sw_abort");
        cyc(0, OP_ST, 3'b010, 0, 1, S_MEMADR, 0, "sw_abort");
        cyc(0, OP_ST, 3'b010, 0, 0, S_MEMWR,  0, "sw_abort");
        cyc(1, OP_ST, 3'b010, 0, 0, S_MEMWR,  0, "sw_abort_reset");
        run_alu(OP_R, 3'b000, S_EXEC_R, 1, "add_after_abort");
        cyc(0, OP_R, 3'b000, 0, 0, S_FETCH, 0, "final");

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
